axis_pkt_arbiter: RTL and testbench
===================================

# axis_pkt_arbiter

Round-robin packet arbiter that merges NUM_PORTS AXI-Stream inputs onto one AXI-Stream output. Grants are held from the first beat to the `tlast` beat, so packets are never interleaved. It sits downstream of a bank of packet-mode `axis_fifo` instances. Each input presents only complete packets, so a granted port never stalls mid-packet for lack of data. The output passes through a single register stage and carries the source port index.

## Interface
Parameters:
- DSIZE, 8, data width per beat
- NUM_PORTS, 4, number of input streams (2..16)
- IDW, 2, port-index width; must equal ceil(log2(NUM_PORTS))

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_tdata  in  NUM_PORTS*DSIZE  port i occupies bits [i*DSIZE +: DSIZE]
- s_tvalid  in  NUM_PORTS  per-port valid
- s_tlast  in  NUM_PORTS  per-port end of packet
- s_tready  out  NUM_PORTS  per-port ready; only the granted bit can be 1
- m_tdata  out  DSIZE  registered output data
- m_tlast  out  1  registered end of packet
- m_tid  out  IDW  index of the source port for the current beat
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- busy  out  1  high while a packet is granted (state BUSY)
- grant  out  IDW  currently or most recently granted port

## Operation
- **State machine:**
  - IDLE: if any s_tvalid bit is set, select a winner, latch it into `grant`, and go to BUSY on the next edge. Otherwise stay in IDLE.
  - BUSY: forward beats from `grant`. A beat with s_tlast accepted (s_tvalid && s_tready on the granted port) returns the FSM to IDLE.
- **Round-robin:**
  - Pointer `last` holds the index of the last port that completed a packet.
  - Search order is last+1, last+2, …, last, modulo NUM_PORTS. The first port with s_tvalid set wins.
  - `last` is updated to `grant` when the tlast beat is accepted.
- **Output stage:**
  - slot_free = !m_tvalid || m_tready.
  - s_tready[grant] = (state==BUSY) && slot_free. All other s_tready bits are 0.
  - On acceptance: m_tdata/m_tlast/m_tid load from the granted port and m_tvalid becomes 1.
  - Otherwise, if m_tready is high, m_tvalid becomes 0.
- **Within a packet:** full throughput of one beat per cycle while m_tready stays high.
- **Single-beat packets:** tlast on the first beat is legal. Grant, then release after one beat.
- **Invalid beats:** s_tvalid on a non-granted port is ignored; its data is never sampled.
- **Back-pressure:** m_tready low with m_tvalid high holds all outputs stable and drops s_tready[grant].

## Timing
- **Reset values:**
  - state = IDLE, last = NUM_PORTS-1 (port 0 has priority first).
  - grant = 0, m_tvalid = 0, m_tdata = 0, m_tlast = 0, m_tid = 0.
  - busy = 0, s_tready = 0.
- **First-beat latency:** s_tvalid rises in cycle 0 (IDLE) → BUSY and s_tready high in cycle 1 → m_tvalid in cycle 2.
- **Between packets:** tlast accepted in cycle N → IDLE in N+1 → next grant BUSY in N+2. This gives exactly one idle arbitration cycle on the input side.
- **Simultaneous requests:** decided by the rotation order only. Ties resolve to the lowest index at or after last+1.
- **Combinational path:** s_tready depends combinationally on m_tready through slot_free. There is no other combinational input→output path.
- **Reset mid-packet:** all state clears immediately. The partial packet is truncated downstream, and the next grant restarts arbitration from port 0.
- **Wrap-around:** the rotation index wraps modulo NUM_PORTS, including when NUM_PORTS is not a power of two. Indices ≥ NUM_PORTS are never granted.

## Structure
- Shared package header: the `clog2` function (used to check IDW) and the state encodings IDLE=1'b0, BUSY=1'b1.
- Sub-module `rr_arbiter` (combinational): inputs are the request vector and `last`; outputs are `any_req` and `winner` index.
- Top level holds the FSM, the `last` and `grant` registers, the data mux, and the output register.

## Test plan
- **Single port:** port 2 sends a 3-beat packet A0,A1,A2(tlast) with m_tready=1 → m_tvalid in cycles 2..4, data A0..A2 in order, m_tid=2, m_tlast only on A2.
- **All ports:** all 4 ports each hold a 2-beat packet continuously after reset → output order is port 0,1,2,3,0, with one-cycle gaps between packets and no interleaving.
- **Back-pressure:** m_tready toggled 1,0,0,1 during a 4-beat packet → no beat lost or duplicated; outputs stable while stalled; s_tready[grant]=0 while m_tvalid && !m_tready.
- **Single-beat packets:** ports 1 and 3 each send tlast on their first beat, with last=1 → port 3 is granted first, then port 1; each grant lasts exactly one beat.
- **Reset mid-packet:** aresetn asserted after beat 2 of a 5-beat packet on port 1 → immediately m_tvalid=0, s_tready=0, busy=0. After release, with ports 0 and 1 requesting, port 0 is granted.
- **Non-granted valid:** port 0 is granted while port 3 raises s_tvalid with garbage data → port 3 data never appears until its own grant, and s_tready[3] stays 0 throughout.

Source files
------------

// File: rtl/axis_pkt_arbiter_pkg.sv
// ============================================================================
// axis_pkt_arbiter_pkg : shared FSM encodings and width helper for the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package axis_pkt_arbiter_pkg;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_arbiter_if.sv
// ============================================================================
// axis_pkt_arbiter_if : input streams, merged output stream and status bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface axis_pkt_arbiter_if #(
  parameter int DSIZE     = 8,
  parameter int NUM_PORTS = 4,
  parameter int IDW       = 2
);

  logic [NUM_PORTS*DSIZE-1:0] s_tdata;
  logic [NUM_PORTS-1:0]       s_tvalid;
  logic [NUM_PORTS-1:0]       s_tlast;
  logic [NUM_PORTS-1:0]       s_tready;
  logic [DSIZE-1:0]           m_tdata;
  logic                       m_tlast;
  logic [IDW-1:0]             m_tid;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       busy;
  logic [IDW-1:0]             grant;

  // Arbiter side
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tlast, m_tid, m_tvalid, busy, grant
  );

  // Environment side: packet sources and output sink
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tlast, m_tid, m_tvalid, busy, grant
  );

endinterface

`default_nettype wire

// File: rtl/axis_pkt_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, searching from last+1 upward
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDW       = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDW-1:0]       last_i,
  output logic                 any_req_o,
  output logic [IDW-1:0]       winner_o
);

  localparam logic [IDW:0] C_NUM_PORTS = (IDW+1)'(NUM_PORTS);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  assign any_req_o = |req_i;

  // Explicit modulo keeps non-power-of-two port counts from ever naming a missing port
  always_comb begin
    winner_o = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_sum = {1'b0, last_i} + (IDW+1)'(k);
      if (w_sum >= C_NUM_PORTS) begin
        w_sum = w_sum - C_NUM_PORTS;
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_found && req_i[w_idx]) begin
        w_found  = 1'b1;
        winner_o = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
// ============================================================================
// axis_pkt_arbiter : round-robin packet-granular AXIS merge, registered output
// Revision 1.0
// ============================================================================
`default_nettype none

module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int NUM_PORTS = 4,
  parameter int IDW       = 2
) (
  input  logic                aclk,
  input  logic                aresetn,
  axis_pkt_arbiter_if.slave   bus
);

  localparam logic [IDW-1:0] C_LAST_RST = IDW'(NUM_PORTS - 1);

  generate
    if (IDW != clog2(NUM_PORTS) || NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_params
      $error("axis_pkt_arbiter: IDW must equal clog2(NUM_PORTS), NUM_PORTS in 2..16");
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [DSIZE-1:0] m_tdata_q;
  logic             m_tlast_q;
  logic [IDW-1:0]   m_tid_q;
  logic             m_tvalid_q;

  logic             w_any_req;
  logic [IDW-1:0]   w_winner;
  logic             w_slot_free;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [DSIZE-1:0] w_sel_data;
  logic             w_accept;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDW       (IDW)
  ) u_rr_arbiter (
    .req_i     (bus.s_tvalid),
    .last_i    (last_q),
    .any_req_o (w_any_req),
    .winner_o  (w_winner)
  );

  assign w_slot_free = !m_tvalid_q || bus.m_tready;
  assign w_sel_valid = bus.s_tvalid[grant_q];
  assign w_sel_last  = bus.s_tlast[grant_q];
  assign w_sel_data  = bus.s_tdata[grant_q*DSIZE +: DSIZE];
  assign w_accept    = (state_q == STATE_BUSY) && w_slot_free && w_sel_valid;

  // Only the granted port ever sees ready; this is the sole comb path from m_tready
  always_comb begin
    bus.s_tready = '0;
    if ((state_q == STATE_BUSY) && w_slot_free) begin
      bus.s_tready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      STATE_IDLE: begin
        if (w_any_req) begin
          grant_d = w_winner;
          state_d = STATE_BUSY;
        end
      end
      STATE_BUSY: begin
        if (w_accept && w_sel_last) begin
          state_d = STATE_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= STATE_IDLE;
      last_q  <= C_LAST_RST;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
      m_tvalid_q <= 1'b0;
    end else if (w_accept) begin
      m_tdata_q  <= w_sel_data;
      m_tlast_q  <= w_sel_last;
      m_tid_q    <= grant_q;
      m_tvalid_q <= 1'b1;
    end else if (bus.m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tid    = m_tid_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.busy     = (state_q == STATE_BUSY);
  assign bus.grant    = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
// ============================================================================
// tb_axis_pkt_arbiter : queue-based packet model versus the arbiter under random traffic
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_axis_pkt_arbiter;

  localparam int DSIZE     = 8;
  localparam int NUM_PORTS = 4;
  localparam int IDW       = 2;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;

  always #5 aclk = ~aclk;

  axis_pkt_arbiter_if #(.DSIZE(DSIZE), .NUM_PORTS(NUM_PORTS), .IDW(IDW)) bus ();

  axis_pkt_arbiter #(
    .DSIZE     (DSIZE),
    .NUM_PORTS (NUM_PORTS),
    .IDW       (IDW)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic [DSIZE-1:0] data;
    logic             last;
    int               id;
    int               cyc;
  } obeat_t;

  beat_t  inq[NUM_PORTS][$];
  beat_t  cp[NUM_PORTS][$];
  obeat_t exp_out[$];
  int     exp_in[$];
  int     model_last;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = DSIZE'($urandom);
      b.last = (i == len - 1);
      inq[p].push_back(b);
    end
  endtask

  // Whole-packet round robin over ports that hold queued packets; with an
  // always-ready sink each packet starts len+1 cycles after the previous one.
  task automatic build_expect(input bit timing);
    int     p;
    int     len;
    int     start;
    beat_t  b;
    obeat_t o;
    start = 2;
    for (int i = 0; i < NUM_PORTS; i++) cp[i] = inq[i];
    while (1) begin
      p = -1;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (p < 0 && cp[(model_last + k) % NUM_PORTS].size() > 0) p = (model_last + k) % NUM_PORTS;
      end
      if (p < 0) break;
      len = 0;
      do begin
        b = cp[p].pop_front();
        o.data = b.data;
        o.last = b.last;
        o.id   = p;
        o.cyc  = timing ? start + len : -1;
        exp_out.push_back(o);
        exp_in.push_back(p);
        len++;
      end while (!b.last);
      start += len + 1;
      model_last = p;
    end
  endtask

  task automatic present();
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (inq[p].size() > 0) begin
        bus.s_tvalid[p]                  = 1'b1;
        bus.s_tdata[p*DSIZE +: DSIZE]    = inq[p][0].data;
        bus.s_tlast[p]                   = inq[p][0].last;
      end else begin
        bus.s_tvalid[p]                  = 1'b0;
        bus.s_tdata[p*DSIZE +: DSIZE]    = DSIZE'($urandom);
        bus.s_tlast[p]                   = 1'($urandom);
      end
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NUM_PORTS; p++) inq[p].delete();
    exp_out.delete();
    exp_in.delete();
    model_last = NUM_PORTS - 1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.m_tready = 1'b0;
    clear_model();
    present();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic run(input bit timing, input bit rnd_ready, input int abort_after, input int max_cycles);
    int                   cyc;
    int                   fires;
    int                   p;
    bit                   stall_prev;
    logic [NUM_PORTS-1:0] acc;
    cyc        = 0;
    fires      = 0;
    stall_prev = 1'b0;
    @(posedge aclk);
    #1;
    present();
    while (exp_out.size() > 0 && cyc < max_cycles) begin
      @(negedge aclk);
      if (stall_prev) check_eq("hold_valid", 32'(bus.m_tvalid), 1);
      bus.m_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      check_eq("ready_onehot", 32'($countones(bus.s_tready) <= 1), 1);
      if (bus.m_tvalid && !bus.m_tready) check_eq("ready_stall", 32'(bus.s_tready), 0);
      acc = bus.s_tvalid & bus.s_tready;
      if (acc != '0) begin
        p = -1;
        for (int i = 0; i < NUM_PORTS; i++) if (acc[i]) p = i;
        if (exp_in.size() == 0) check_eq("in_order", 32'(p), 32'hff);
        else                    check_eq("in_order", 32'(p), 32'(exp_in.pop_front()));
      end
      if (bus.m_tvalid) begin
        if (exp_out.size() == 0) begin
          check_eq("spurious_valid", 32'(bus.m_tvalid), 0);
        end else begin
          check_eq("m_tdata", 32'(bus.m_tdata), 32'(exp_out[0].data));
          check_eq("m_tlast", 32'(bus.m_tlast), 32'(exp_out[0].last));
          check_eq("m_tid",   32'(bus.m_tid),   32'(exp_out[0].id));
          if (bus.m_tready) begin
            if (timing) check_eq("beat_cycle", 32'(cyc), 32'(exp_out[0].cyc));
            void'(exp_out.pop_front());
            fires++;
          end
        end
      end
      stall_prev = bus.m_tvalid && !bus.m_tready;
      if (abort_after > 0 && fires >= abort_after) return;
      @(posedge aclk);
      #1;
      for (int i = 0; i < NUM_PORTS; i++) if (acc[i]) void'(inq[i].pop_front());
      present();
      cyc++;
    end
    check_eq("drain_timeout", 32'(exp_out.size()), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_m_tvalid"}, 32'(bus.m_tvalid), 0);
    check_eq({tag, "_s_tready"}, 32'(bus.s_tready), 0);
    check_eq({tag, "_busy"},     32'(bus.busy), 0);
    check_eq({tag, "_grant"},    32'(bus.grant), 0);
  endtask

  initial begin
    bus.m_tready = 1'b0;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    clear_model();
    #1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_idle_outputs("rst");
    check_eq("rst_m_tdata", 32'(bus.m_tdata), 0);
    check_eq("rst_m_tlast", 32'(bus.m_tlast), 0);
    check_eq("rst_m_tid",   32'(bus.m_tid), 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single 3-beat packet on port 2: beats in cycles 2..4
    add_pkt(2, 3);
    build_expect(1'b1);
    run(1'b1, 1'b0, 0, 200);

    // Every port backlogged: order 0,1,2,3,0 with one-cycle gaps
    do_reset();
    add_pkt(0, 2);
    add_pkt(0, 2);
    add_pkt(1, 2);
    add_pkt(2, 2);
    add_pkt(3, 2);
    build_expect(1'b1);
    run(1'b1, 1'b0, 0, 300);

    // Single-beat packets with last=1: port 3 wins before port 1
    do_reset();
    add_pkt(1, 1);
    build_expect(1'b1);
    run(1'b1, 1'b0, 0, 100);
    add_pkt(1, 1);
    add_pkt(3, 1);
    build_expect(1'b1);
    run(1'b1, 1'b0, 0, 100);

    // Reset after two beats of a 5-beat packet on port 1
    add_pkt(1, 5);
    build_expect(1'b0);
    run(1'b0, 1'b0, 2, 100);
    aresetn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    clear_model();
    present();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    add_pkt(0, 2);
    add_pkt(1, 2);
    build_expect(1'b1);
    run(1'b1, 1'b0, 0, 100);

    // Port 3 valid while port 0 holds the grant, with back-pressure
    do_reset();
    add_pkt(0, 4);
    add_pkt(3, 3);
    build_expect(1'b0);
    run(1'b0, 1'b1, 0, 300);

    // Random traffic and random sink stalls
    for (int it = 0; it < 15; it++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int j = 0; j < npk; j++) add_pkt(p, $urandom_range(1, 4));
      end
      build_expect(1'b0);
      run(1'b0, 1'b1, 0, 1000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
